fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined CPU. It owns the program counter and drives the word address into the instruction memory. It captures the returned instruction into the IF/ID pipeline register. It applies stall, branch, jump and halt control from the decode and hazard logic, and keeps a retired-fetch counter for bench and debug use.

## Interface
Parameters:
- RESET_PC, 32'd0: PC value loaded on reset.
- IMEM_WORDS, 1024: instruction memory depth in words. Valid byte addresses are 0 to IMEM_WORDS*4-4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit; hold PC and IF/ID.
- branch_taken  in  1  taken branch resolved in ID.
- branch_target  in  32  byte address of the branch target.
- jump  in  1  j/jr resolved in ID.
- jump_target  in  32  byte address of the jump target.
- halt  in  1  halt request from decode.
- imem_address  out  32  byte address to the instruction memory (memory indexes address/4).
- imem_instruction  in  32  instruction word returned by the memory.
- ifid_instruction  out  32  IF/ID instruction; 32'd0 (nop) when invalid.
- ifid_pc_plus4  out  32  IF/ID PC+4 of the captured instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch has stopped.
- fetch_count  out  32  number of instructions captured with ifid_valid=1.

## Operation
- State machine:
  - RUN: normal fetching.
  - HALTED: PC, IF/ID contents and fetch_count frozen; ifid_valid=0; halted=1. Only reset leaves HALTED.
- imem_address is combinational and equals the PC register.
- Next-PC priority each edge (highest first):
  1. reset: PC=RESET_PC.
  2. HALTED: hold.
  3. halt: enter HALTED, hold PC.
  4. branch_taken: PC=branch_target.
  5. jump: PC=jump_target.
  6. stall: hold.
  7. Otherwise: PC+4.
- Redirect (branch_taken or jump) overrides stall. When both are high, branch_taken wins.
- Redirect flushes IF/ID: ifid_instruction=0, ifid_valid=0, ifid_pc_plus4=0. The wrong-path word in memory is discarded.
- Targets have bits [1:0] forced to 2'b00 before loading into the PC.
- Sequential capture (RUN, no redirect, no stall, no halt): ifid_instruction=imem_instruction, ifid_pc_plus4=PC+4, ifid_valid=1, fetch_count+=1.
- stall without redirect: IF/ID and fetch_count hold their values.
- PC+4 arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- Out-of-range PC (PC ≥ IMEM_WORDS*4) in RUN:
  - No capture takes place; IF/ID loads a nop with ifid_valid=0.
  - The state moves to HALTED on that edge.
  - A same-cycle redirect takes priority: it loads the new PC and stays in RUN.
- fetch_count wraps modulo 2^32.
- Reset values: PC=RESET_PC, ifid_instruction=0, ifid_pc_plus4=0, ifid_valid=0, halted=0, fetch_count=0, state=RUN.
- Reset asserted mid-operation applies on the next edge regardless of stall, halt or redirect.

## Timing
- The instruction memory is combinational with a 1000-time-unit output delay. The clk period must exceed 1000 plus the IF/ID setup time; benches use a 10000 period.
- imem_address changes only after a rising edge. imem_instruction must be stable before the next rising edge.
- Fetch latency: the instruction at PC appears on ifid_instruction one edge after PC is presented.
- Redirect latency: the target is on imem_address the edge after branch_taken or jump is sampled. The target instruction reaches IF/ID one edge later, giving a one-cycle bubble.
- The first valid IF/ID word appears on the first non-reset edge after reset deasserts.
- halt sampled at edge N: halted=1 after edge N, and the instruction present at edge N is not captured.

## Test plan
- Reset then free-run with mem[0..3]=A,B,C,D:
  - After edges 1 to 4, ifid_instruction = A, B, C, D.
  - ifid_pc_plus4 = 4, 8, 12, 16.
  - fetch_count = 4.
- Stall for 2 cycles at PC=8: PC holds at 8, IF/ID holds B, fetch_count holds at 2. Release: C is captured with pc_plus4=12.
- branch_taken with target 32'h00000043 while stall=1:
  - Next edge: imem_address=0x40, ifid_valid=0, ifid_instruction=0.
  - Following edge: mem[16] is captured with pc_plus4=0x44.
- branch_taken and jump in the same cycle (targets 0x20 and 0x80): PC=0x20.
- halt at PC=12:
  - halted=1, ifid_valid=0, and PC stays 12 for 5 further cycles.
  - Asserting reset gives PC=0, halted=0, fetch_count=0.
- Sequential run to PC=4092 with IMEM_WORDS=1024:
  - The word at 4092 is captured.
  - The next edge has PC=4096, out of range, which forces HALTED with ifid_valid=0.
  - Repeat with jump to 0 asserted at PC=4096: the block stays in RUN with PC=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and loads the IF/ID register under stall, redirect, halt and range control.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int unsigned ADDR_W     = 32;
    localparam logic [ADDR_W:0] IMEM_BYTES = (ADDR_W+1)'(IMEM_WORDS) * (ADDR_W+1)'(4);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [31:0]       instr_n;
    logic [ADDR_W-1:0] pc4_n;
    logic              valid_n;
    logic [31:0]       count_n;
    logic [ADDR_W-1:0] pc_plus4;
    logic              out_of_range;

    assign imem_address = pc;
    assign halted       = (state == HALTED);
    assign pc_plus4     = pc + ADDR_W'(4);
    assign out_of_range = ({1'b0, pc} >= IMEM_BYTES);

    // State and pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            pc               <= RESET_PC;
            ifid_instruction <= 32'd0;
            ifid_pc_plus4    <= 32'd0;
            ifid_valid       <= 1'b0;
            fetch_count      <= 32'd0;
        end else begin
            state            <= state_n;
            pc               <= pc_n;
            ifid_instruction <= instr_n;
            ifid_pc_plus4    <= pc4_n;
            ifid_valid       <= valid_n;
            fetch_count      <= count_n;
        end
    end

    // Next-PC selection and IF/ID load; redirect beats stall, halt beats redirect
    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = ifid_instruction;
        pc4_n   = ifid_pc_plus4;
        valid_n = ifid_valid;
        count_n = fetch_count;

        case (state)
            RUN: begin
                if (halt) begin
                    state_n = HALTED;
                    instr_n = 32'd0;
                    valid_n = 1'b0;
                end else if (branch_taken) begin
                    pc_n    = {branch_target[31:2], 2'b00};
                    instr_n = 32'd0;
                    pc4_n   = 32'd0;
                    valid_n = 1'b0;
                end else if (jump) begin
                    pc_n    = {jump_target[31:2], 2'b00};
                    instr_n = 32'd0;
                    pc4_n   = 32'd0;
                    valid_n = 1'b0;
                end else if (out_of_range) begin
                    state_n = HALTED;
                    instr_n = 32'd0;
                    valid_n = 1'b0;
                end else if (!stall) begin
                    pc_n    = pc_plus4;
                    instr_n = imem_instruction;
                    pc4_n   = pc_plus4;
                    valid_n = 1'b1;
                    count_n = fetch_count + 32'd1;
                end
            end
            HALTED: begin
                valid_n = 1'b0;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

endmodule
